cam_capture_maxis: RTL and testbench
====================================

# cam_capture_maxis

Captures the 8-bit parallel pixel bus of an OV7670-class camera and packs each pair of bytes into a 16-bit pixel. Pixels are emitted as an AXI4-Stream video master with start-of-frame (TUSER) and end-of-line (TLAST) markers. The block sits between the camera pins and the video DMA/VDMA input. It runs entirely in the camera pixel-clock domain.

## Interface
Parameters:
- X_RES, default 640: pixels per line (2·X_RES bytes per HREF window).
- Y_RES, default 480: lines per frame.

Ports:
- i_pclk  input  1  camera pixel clock; all logic on its rising edge.
- i_resetn  input  1  reset, asynchronous and active-high: asserted when 1, despite the suffix.
- i_enable  input  1  capture enable; a frame starts only if high at VSYNC.
- i_vsync  input  1  camera VSYNC, high between frames.
- i_href  input  1  camera HREF, high while line bytes are valid.
- i_data  input  8  camera data byte.
- M_AXIS_VIDEO_TDATA  output  16  pixel, {second byte, first byte}.
- M_AXIS_TVALID  output  1  pixel valid strobe.
- M_AXIS_VIDEO_TREADY  input  1  ignored; the camera cannot be stalled. May be left unconnected.
- M_AXIS_VIDEO_TUSER  output  1  start of frame; set on the first pixel after VSYNC.
- M_AXIS_VIDEO_TLAST  output  1  end of line; set on pixel X_RES-1 of each line.

## Operation
- Reset values: all outputs 0, FSM in IDLE, byte phase 0, pixel and line counters 0.
- FSM states:
  - IDLE → WAIT_VS_END when i_vsync=1 and i_enable=1.
  - WAIT_VS_END → CAPTURE when i_vsync falls; the SOF flag is armed.
  - CAPTURE → IDLE after Y_RES lines complete.
- i_vsync=1 while in CAPTURE restarts the frame: go to WAIT_VS_END, clear counters and phase.
- i_enable low: the current frame completes, then the FSM stays in IDLE.
- In CAPTURE, each rising edge with i_href=1 samples i_data:
  - Phase 0: store the byte as low byte.
  - Phase 1: form TDATA = {i_data, low byte}, pulse TVALID, increment the pixel counter.
- When i_href is low, phase resets to 0. An odd trailing byte is discarded.
- Line counting:
  - Pixel counter wraps to 0 after X_RES-1; that pixel carries TLAST=1.
  - Each TLAST increments the line counter.
  - Lines beyond Y_RES are ignored until the next VSYNC.
- TUSER=1 only on the first pixel after an armed SOF, then the SOF flag clears.
- A short line (HREF falls before X_RES pixels): the pixel counter resets at HREF fall and no TLAST is generated for that line.
- TREADY is never examined. Downstream must accept one pixel per 2 pclk.

## Timing
- TVALID, TDATA, TUSER and TLAST are registered and assert on the rising edge that samples the second byte. They are visible to a consumer sampling on the next rising edge.
- TVALID is high for exactly one cycle per pixel; it is never asserted on consecutive cycles.
- TDATA holds its last value while TVALID=0.
- TUSER and TLAST are 0 whenever TVALID=0.
- Reset asserted mid-line: outputs go to 0 immediately, and no pixels are emitted until the next VSYNC sequence.
- Zero pixel loss: every byte pair inside HREF of a captured frame produces exactly one TVALID pulse, in order.

## Test plan
- Basic line:
  - Stimulus: X_RES=64, Y_RES=3, reset released, enable=1, VSYNC high for 128 pclk, then one 128-byte HREF line of random bytes.
  - Required: 64 TVALID pulses, TDATA[i] = {byte[2i+1], byte[2i]}, in order.
- Frame markers:
  - Stimulus: same setup, 3 lines, 1 idle pclk between lines.
  - Required: TUSER=1 only on pixel 0 of line 0; TLAST=1 on pixels 63, 127, 191; 192 pixels total.
- Multi-frame:
  - Stimulus: 3 consecutive frames, each preceded by VSYNC.
  - Required: TUSER re-asserts at the start of each frame; data matches per frame; no pixels appear during VSYNC.
- Enable low:
  - Stimulus: i_enable=0, then a VSYNC and a line.
  - Required: TVALID stays 0.
  - Stimulus: raise i_enable, then the next VSYNC and a line.
  - Required: capture resumes with TUSER on the first pixel.
- Odd byte / short line:
  - Stimulus: HREF window of 5 bytes.
  - Required: 2 pixels out, the 5th byte dropped, no TLAST; the next full line starts at pixel 0.
- Reset mid-frame:
  - Stimulus: assert reset during line 1.
  - Required: outputs go to 0 asynchronously; no output until a new VSYNC; the following frame is captured correctly.

Source files
------------

// File: rtl/cam_capture_maxis.sv
// OV7670-class parallel camera capture: packs byte pairs into 16-bit pixels and
// emits them as an AXI4-Stream video master with SOF (TUSER) and EOL (TLAST).
module cam_capture_maxis #(
  parameter int unsigned X_RES = 640,
  parameter int unsigned Y_RES = 480
) (
  input  logic        i_pclk,
  input  logic        i_resetn,
  input  logic        i_enable,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic [15:0] M_AXIS_VIDEO_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_VIDEO_TREADY,
  output logic        M_AXIS_VIDEO_TUSER,
  output logic        M_AXIS_VIDEO_TLAST
);

  localparam int unsigned PIX_W  = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int unsigned LINE_W = $clog2(Y_RES + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_VS_END = 2'd1,
    CAPTURE     = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              phase, phase_nxt;
  logic [7:0]        low_byte, low_byte_nxt;
  logic [PIX_W-1:0]  pix_cnt, pix_cnt_nxt;
  logic [LINE_W-1:0] line_cnt, line_cnt_nxt;
  logic              sof, sof_nxt;
  logic [15:0]       tdata_nxt;
  logic              tvalid_nxt, tuser_nxt, tlast_nxt;

  logic capturing_c;
  logic pixel_c;
  logic end_line_c;
  logic end_frame_c;

  // The camera cannot be stalled, so backpressure is deliberately ignored.
  logic unused_tready;
  assign unused_tready = M_AXIS_VIDEO_TREADY;

  // VSYNC inside a frame aborts it, so data is only taken while VSYNC is low.
  assign capturing_c = (state == CAPTURE) && !i_vsync;
  assign pixel_c     = capturing_c && i_href && phase;
  assign end_line_c  = pixel_c && (pix_cnt == PIX_W'(X_RES - 1));
  assign end_frame_c = end_line_c && (line_cnt == LINE_W'(Y_RES - 1));

  // State register.
  always_ff @(posedge i_pclk or posedge i_resetn) begin
    if (i_resetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_vsync && i_enable) state_nxt = WAIT_VS_END;
      end
      WAIT_VS_END: begin
        if (!i_vsync) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (i_vsync)          state_nxt = i_enable ? WAIT_VS_END : IDLE;
        else if (end_frame_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    phase_nxt    = phase;
    low_byte_nxt = low_byte;
    pix_cnt_nxt  = pix_cnt;
    line_cnt_nxt = line_cnt;
    sof_nxt      = sof;
    tdata_nxt    = M_AXIS_VIDEO_TDATA;
    tvalid_nxt   = 1'b0;
    tuser_nxt    = 1'b0;
    tlast_nxt    = 1'b0;

    if (!capturing_c) begin
      phase_nxt    = 1'b0;
      pix_cnt_nxt  = '0;
      line_cnt_nxt = '0;
      if (state == WAIT_VS_END && state_nxt == CAPTURE) sof_nxt = 1'b1;
    end else if (!i_href) begin
      // Short lines and odd trailing bytes are dropped here.
      phase_nxt   = 1'b0;
      pix_cnt_nxt = '0;
    end else if (!phase) begin
      phase_nxt    = 1'b1;
      low_byte_nxt = i_data;
    end else begin
      phase_nxt  = 1'b0;
      tvalid_nxt = 1'b1;
      tdata_nxt  = {i_data, low_byte};
      tuser_nxt  = sof;
      sof_nxt    = 1'b0;
      if (end_line_c) begin
        tlast_nxt    = 1'b1;
        pix_cnt_nxt  = '0;
        line_cnt_nxt = line_cnt + LINE_W'(1);
      end else begin
        pix_cnt_nxt = pix_cnt + PIX_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_pclk or posedge i_resetn) begin
    if (i_resetn) begin
      phase              <= 1'b0;
      low_byte           <= '0;
      pix_cnt            <= '0;
      line_cnt           <= '0;
      sof                <= 1'b0;
      M_AXIS_VIDEO_TDATA <= '0;
      M_AXIS_TVALID      <= 1'b0;
      M_AXIS_VIDEO_TUSER <= 1'b0;
      M_AXIS_VIDEO_TLAST <= 1'b0;
    end else begin
      phase              <= phase_nxt;
      low_byte           <= low_byte_nxt;
      pix_cnt            <= pix_cnt_nxt;
      line_cnt           <= line_cnt_nxt;
      sof                <= sof_nxt;
      M_AXIS_VIDEO_TDATA <= tdata_nxt;
      M_AXIS_TVALID      <= tvalid_nxt;
      M_AXIS_VIDEO_TUSER <= tuser_nxt;
      M_AXIS_VIDEO_TLAST <= tlast_nxt;
    end
  end

endmodule

// File: tb/tb_cam_capture_maxis.sv
// Bench for cam_capture_maxis: random camera lines against a frame/line/pixel
// reference model; a negedge monitor collects emitted pixels.
module tb_cam_capture_maxis;

  localparam int unsigned X_RES = 64;
  localparam int unsigned Y_RES = 3;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [15:0] data;
  } px_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  px_t obs_q[$];
  px_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  int          consec = 0;
  int          hold_err = 0;
  int          side_err = 0;
  int          vs_px = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] last_tdata = '0;

  // Reference model state: is a frame being captured, SOF pending, full lines seen.
  bit m_cap   = 1'b0;
  bit m_sof   = 1'b0;
  int m_lines = 0;

  always #5 clk = ~clk;

  cam_capture_maxis #(.X_RES(X_RES), .Y_RES(Y_RES)) dut (
    .i_pclk              (clk),
    .i_resetn            (rst),
    .i_enable            (enable),
    .i_vsync             (vsync),
    .i_href              (href),
    .i_data              (data),
    .M_AXIS_VIDEO_TDATA  (tdata),
    .M_AXIS_TVALID       (tvalid),
    .M_AXIS_VIDEO_TREADY (tready),
    .M_AXIS_VIDEO_TUSER  (tuser),
    .M_AXIS_VIDEO_TLAST  (tlast)
  );

  // Monitor: collect pixels and tally stream-protocol violations.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      last_tdata = '0;
    end else begin
      if (tvalid) begin
        obs_q.push_back({tuser, tlast, tdata});
        if (prev_valid) consec++;
        if (vsync) vs_px++;
      end else begin
        if (tdata !== last_tdata) hold_err++;
        if (tuser || tlast) side_err++;
      end
      prev_valid = tvalid;
      last_tdata = tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    href = 1'b0;
    repeat (6) tick();
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_vsync(input int n);
    href  = 1'b0;
    vsync = 1'b1;
    repeat (n) tick();
    vsync = 1'b0;
    repeat (2) tick();
    m_cap   = enable;
    m_sof   = enable;
    m_lines = 0;
  endtask

  // Drive one HREF window of random bytes and extend the model's expectations.
  task automatic send_line(input int len, input bit close);
    logic [7:0] b[$];
    b = {};
    for (int k = 0; k < len; k++) begin
      b.push_back(8'($urandom));
      href = 1'b1;
      data = b[k];
      tick();
    end
    if (close) begin
      href = 1'b0;
      tick();
    end
    if (m_cap && m_lines < int'(Y_RES)) begin
      for (int i = 0; i < len / 2; i++) begin
        px_t p;
        p.data = {b[2*i+1], b[2*i]};
        p.user = m_sof;
        p.last = (i == int'(X_RES) - 1);
        m_sof  = 1'b0;
        exp_q.push_back(p);
        if (p.last) m_lines++;
      end
      if (m_lines == int'(Y_RES)) m_cap = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0; data = '0; tready = 1'b1;
    repeat (3) tick();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    checks++; if (tdata !== 16'h0) begin errors++; $display("FAIL reset_tdata got %h want 0000", tdata); end
    checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b want 0", tuser); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic_line();
    clear_q();
    enable = 1'b1;
    do_vsync(128);
    send_line(128, 1'b1);
    settle();
    checks++;
    if (obs_q.size() != 64) begin errors++; $display("FAIL basic_count got %0d want 64", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_px%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame_markers();
    int n_user, n_last;
    clear_q();
    do_vsync(128);
    for (int l = 0; l < 4; l++) send_line(128, 1'b1);  // 4th line is beyond Y_RES
    settle();
    n_user = 0; n_last = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].user) n_user++;
      if (obs_q[i].last) n_last++;
    end
    checks++;
    if (obs_q.size() != 192) begin errors++; $display("FAIL frame_count got %0d want 192", obs_q.size()); end
    checks++;
    if (n_user != 1) begin errors++; $display("FAIL frame_tuser_count got %0d want 1", n_user); end
    checks++;
    if (n_last != 3) begin errors++; $display("FAIL frame_tlast_count got %0d want 3", n_last); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_px%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_multi_frame();
    clear_q();
    for (int f = 0; f < 3; f++) begin
      do_vsync(20 + f * 7);
      for (int l = 0; l < 3; l++) send_line(128, 1'b1);
    end
    settle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_px%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_low();
    clear_q();
    enable = 1'b0;
    do_vsync(32);
    send_line(128, 1'b1);
    settle();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL disabled_count got %0d want 0", obs_q.size()); end
    clear_q();
    enable = 1'b1;
    do_vsync(32);
    send_line(128, 1'b1);
    settle();
    checks++;
    if (obs_q.size() != 64) begin errors++; $display("FAIL resume_count got %0d want 64", obs_q.size()); end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].user !== 1'b1) begin errors++; $display("FAIL resume_tuser got %b want 1", obs_q[0].user); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL resume_px%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_short_line();
    clear_q();
    do_vsync(16);
    send_line(5, 1'b1);
    send_line(128, 1'b1);
    settle();
    checks++;
    if (obs_q.size() != 66) begin errors++; $display("FAIL short_count got %0d want 66", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_px%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    do_vsync(40);
    send_line(128, 1'b1);
    send_line(41, 1'b0);  // HREF still high, odd byte pending
    @(negedge clk);
    #1 rst = 1'b1;
    m_cap = 1'b0;
    m_sof = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b want 0", tvalid); end
    checks++; if (tdata !== 16'h0) begin errors++; $display("FAIL midrst_tdata got %h want 0000", tdata); end
    checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL midrst_tuser got %b want 0", tuser); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL midrst_tlast got %b want 0", tlast); end
    repeat (2) tick();
    rst = 1'b0;
    send_line(87, 1'b1);
    send_line(128, 1'b1);
    do_vsync(64);
    for (int l = 0; l < 3; l++) send_line(128, 1'b1);
    settle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_px%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_protocol();
    checks++; if (consec != 0) begin errors++; $display("FAIL back_to_back_valid got %0d want 0", consec); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL tdata_hold got %0d want 0", hold_err); end
    checks++; if (side_err != 0) begin errors++; $display("FAIL marker_without_valid got %0d want 0", side_err); end
    checks++; if (vs_px != 0) begin errors++; $display("FAIL pixel_during_vsync got %0d want 0", vs_px); end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_frame_markers();
    test_multi_frame();
    test_enable_low();
    test_short_line();
    test_reset_midframe();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
